// File: rtl/ttc_pkg.sv
// Shared definitions for the CCB fast-command scheduler: command codes, orbit lengths
// and the resync sequencer state encoding. Sequencer is enabled by TTC_RESYNC_SEQ_EN.
package ttc_pkg;

  localparam logic [5:0] CMD_BC0        = 6'd1;
  localparam logic [5:0] CMD_L1RESET    = 6'd3;
  localparam logic [5:0] CMD_START_TRIG = 6'd6;
  localparam logic [5:0] CMD_STOP_TRIG  = 6'd7;

  localparam logic [11:0] LHC_CYCLE_LONG  = 12'd3564;
  localparam logic [11:0] LHC_CYCLE_SHORT = 12'd924;

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_STOP  = 3'd1,
    SEQ_L1R   = 3'd2,
    SEQ_ORB   = 3'd3,
    SEQ_START = 3'd4
  } seq_state_e;

  function automatic logic [11:0] lhc_cycle_len(input logic sel);
    return sel ? LHC_CYCLE_LONG : LHC_CYCLE_SHORT;
  endfunction

endpackage

// File: rtl/ttc_resync_seq.sv
// Resync sequencer: stop_trigger, l1reset, bc0 on the last BX of the orbit, start_trigger.
// Only instantiated by ttc_cmd_sched when TTC_RESYNC_SEQ_EN is defined.
module ttc_resync_seq
  import ttc_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        resync_req_i,
  input  logic [11:0] bxn_counter_i,
  input  logic [11:0] lhc_cycle_i,
  input  logic        seq_grant_i,
  output logic        seq_req_o,
  output logic [5:0]  seq_cmd_o,
  output logic        seq_busy_o,
  output logic        resync_drop_o
);

  seq_state_e state_q;
  logic       busy_q;
  logic       drop_q;
  logic       orb_match_s;

  // Equality also excludes any bxn at or beyond the orbit length.
  assign orb_match_s = (bxn_counter_i == (lhc_cycle_i - 12'd1));

  always_comb begin
    seq_req_o = 1'b0;
    seq_cmd_o = 6'd0;
    case (state_q)
      SEQ_STOP:  begin seq_req_o = 1'b1;        seq_cmd_o = CMD_STOP_TRIG;  end
      SEQ_L1R:   begin seq_req_o = 1'b1;        seq_cmd_o = CMD_L1RESET;    end
      SEQ_ORB:   begin seq_req_o = orb_match_s; seq_cmd_o = CMD_BC0;        end
      SEQ_START: begin seq_req_o = 1'b1;        seq_cmd_o = CMD_START_TRIG; end
      default:   begin seq_req_o = 1'b0;        seq_cmd_o = 6'd0;           end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SEQ_IDLE;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= resync_req_i && (state_q != SEQ_IDLE);
      case (state_q)
        SEQ_IDLE: begin
          if (resync_req_i) begin
            state_q <= SEQ_STOP;
            busy_q  <= 1'b1;
          end
        end
        SEQ_STOP:  if (seq_grant_i) state_q <= SEQ_L1R;
        SEQ_L1R:   if (seq_grant_i) state_q <= SEQ_ORB;
        SEQ_ORB:   if (seq_grant_i) state_q <= SEQ_START;
        SEQ_START: begin
          if (seq_grant_i) begin
            state_q <= SEQ_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= SEQ_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign seq_busy_o    = busy_q;
  assign resync_drop_o = drop_q;

endmodule

// File: rtl/ttc_cmd_sched.sv
// CCB fast-command scheduler: holdoff, sequencer > tp > sc arbitration, registered outputs.
// Define TTC_RESYNC_SEQ_EN to compile in the resync sequencer.
module ttc_cmd_sched
  import ttc_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lhc_cycle_sel_i,
  input  logic [11:0] bxn_counter_i,
  input  logic        sc_req_i,
  input  logic [5:0]  sc_cmd_i,
  output logic        sc_ack_o,
  input  logic        tp_req_i,
  input  logic [5:0]  tp_cmd_i,
  input  logic [11:0] tp_bx_i,
  output logic        tp_ack_o,
  input  logic        resync_req_i,
  output logic        seq_busy_o,
  output logic        resync_drop_o,
  output logic [5:0]  ccb_cmd_o,
  output logic        ccb_cmd_strobe_o
);

  // The counter becomes visible one cycle after the grant, so loading GAP-1
  // spaces consecutive strobes by exactly GAP_CYCLES.
  localparam logic [7:0] HOLD_LOAD = 8'(GAP_CYCLES - 1);

  logic [7:0] holdoff_q, holdoff_d;
  logic [5:0] cmd_q, cmd_d;
  logic       strobe_q, strobe_d;
  logic       sc_ack_q, tp_ack_q;
  logic       sc_grant_s, tp_grant_s, seq_grant_s;
  logic       seq_req_s;
  logic [5:0] seq_cmd_s;
  logic       tp_match_s;

`ifdef TTC_RESYNC_SEQ_EN
  logic [11:0] lhc_cycle_s;
  assign lhc_cycle_s = lhc_cycle_len(lhc_cycle_sel_i);

  ttc_resync_seq u_seq (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .resync_req_i  (resync_req_i),
    .bxn_counter_i (bxn_counter_i),
    .lhc_cycle_i   (lhc_cycle_s),
    .seq_grant_i   (seq_grant_s),
    .seq_req_o     (seq_req_s),
    .seq_cmd_o     (seq_cmd_s),
    .seq_busy_o    (seq_busy_o),
    .resync_drop_o (resync_drop_o)
  );
`else
  logic unused_seq_inputs_s;
  assign unused_seq_inputs_s = resync_req_i ^ lhc_cycle_sel_i;
  assign seq_req_s     = 1'b0;
  assign seq_cmd_s     = 6'd0;
  assign seq_busy_o    = 1'b0;
  assign resync_drop_o = 1'b0;
`endif

  assign tp_match_s = tp_req_i && (bxn_counter_i == tp_bx_i);

  always_comb begin
    sc_grant_s  = 1'b0;
    tp_grant_s  = 1'b0;
    seq_grant_s = 1'b0;
    cmd_d       = cmd_q;
    if (holdoff_q == 8'd0) begin
      if (seq_req_s) begin
        seq_grant_s = 1'b1;
        cmd_d       = seq_cmd_s;
      end else if (tp_match_s) begin
        tp_grant_s = 1'b1;
        cmd_d      = tp_cmd_i;
      end else if (sc_req_i) begin
        sc_grant_s = 1'b1;
        cmd_d      = sc_cmd_i;
      end else begin
        cmd_d = cmd_q;
      end
    end else begin
      cmd_d = cmd_q;
    end
  end

  assign strobe_d = seq_grant_s | tp_grant_s | sc_grant_s;

  always_comb begin
    holdoff_d = holdoff_q;
    if (strobe_d) begin
      holdoff_d = HOLD_LOAD;
    end else if (holdoff_q != 8'd0) begin
      holdoff_d = holdoff_q - 8'd1;
    end else begin
      holdoff_d = holdoff_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      holdoff_q <= 8'd0;
      cmd_q     <= 6'd0;
      strobe_q  <= 1'b0;
      sc_ack_q  <= 1'b0;
      tp_ack_q  <= 1'b0;
    end else begin
      holdoff_q <= holdoff_d;
      cmd_q     <= cmd_d;
      strobe_q  <= strobe_d;
      sc_ack_q  <= sc_grant_s;
      tp_ack_q  <= tp_grant_s;
    end
  end

  assign ccb_cmd_o        = cmd_q;
  assign ccb_cmd_strobe_o = strobe_q;
  assign sc_ack_o         = sc_ack_q;
  assign tp_ack_o         = tp_ack_q;

endmodule

// File: tb/tb_ttc_cmd_sched.sv
// Bench for ttc_cmd_sched: directed vector table, corner-case sequences and random traffic
// checked against a queue-based reference model. Sequencer cases need TTC_RESYNC_SEQ_EN.
module tb_ttc_cmd_sched;

  localparam int GAP = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic [11:0] bxn = 12'd0;
  logic        sc_req = 1'b0;
  logic [5:0]  sc_cmd = 6'd0;
  logic        tp_req = 1'b0;
  logic [5:0]  tp_cmd = 6'd0;
  logic [11:0] tp_bx = 12'd0;
  logic        resync = 1'b0;
  logic        sca, tpa, busy, drop, stb;
  logic [5:0]  cmd;

  int n_checks = 0;
  int n_fail   = 0;

  ttc_cmd_sched #(.GAP_CYCLES(GAP)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .lhc_cycle_sel_i  (sel),
    .bxn_counter_i    (bxn),
    .sc_req_i         (sc_req),
    .sc_cmd_i         (sc_cmd),
    .sc_ack_o         (sca),
    .tp_req_i         (tp_req),
    .tp_cmd_i         (tp_cmd),
    .tp_bx_i          (tp_bx),
    .tp_ack_o         (tpa),
    .resync_req_i     (resync),
    .seq_busy_o       (busy),
    .resync_drop_o    (drop),
    .ccb_cmd_o        (cmd),
    .ccb_cmd_strobe_o (stb)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] orbit_len(input logic s);
    return s ? 12'd3564 : 12'd924;
  endfunction

  function automatic logic [11:0] next_bx(input logic [11:0] b, input logic s);
    return ((b + 12'd1) >= orbit_len(s)) ? 12'd0 : b + 12'd1;
  endfunction

  // Reference model: strobe spacing by timestamps, sequencer as a queue of pending commands.
  int          m_cyc  = 0;
  int          m_last = -1000;
  logic [5:0]  m_cmd  = 6'd0;
  logic [5:0]  m_seq[$];
  logic [10:0] exp_vec;

  task automatic model_eval();
    logic e_stb, e_sca, e_tpa, e_drop, seq_go, ok;
    int   pre;
    e_stb = 1'b0; e_sca = 1'b0; e_tpa = 1'b0; e_drop = 1'b0; seq_go = 1'b0;
    if (rst) begin
      m_last = -1000;
      m_seq.delete();
      m_cmd = 6'd0;
      exp_vec = 11'd0;
    end else begin
      ok  = ((m_cyc + 1 - m_last) >= GAP);
      pre = m_seq.size();
`ifdef TTC_RESYNC_SEQ_EN
      if (pre > 0) seq_go = (m_seq[0] != 6'd1) || (bxn == orbit_len(sel) - 12'd1);
`endif
      if (ok && seq_go) begin
        e_stb = 1'b1; m_cmd = m_seq.pop_front();
      end else if (ok && tp_req && bxn == tp_bx) begin
        e_stb = 1'b1; e_tpa = 1'b1; m_cmd = tp_cmd;
      end else if (ok && sc_req) begin
        e_stb = 1'b1; e_sca = 1'b1; m_cmd = sc_cmd;
      end
      if (e_stb) m_last = m_cyc + 1;
`ifdef TTC_RESYNC_SEQ_EN
      if (resync) begin
        if (pre > 0) e_drop = 1'b1;
        else m_seq = '{6'd7, 6'd3, 6'd1, 6'd6};
      end
`endif
      exp_vec = {m_seq.size() > 0, e_drop, e_tpa, e_sca, e_stb, m_cmd};
    end
    m_cyc++;
  endtask

  task automatic mstep(input string name);
    model_eval();
    tick();
    bxn = next_bx(bxn, sel);
    check(name, {21'd0, busy, drop, tpa, sca, stb, cmd}, {21'd0, exp_vec});
  endtask

  typedef struct {
    logic        rst, sc_req;
    logic [5:0]  sc_cmd;
    logic        tp_req;
    logic [5:0]  tp_cmd;
    logic [11:0] tp_bx, bxn;
    int          n;
    logic        stb;
    logic [5:0]  cmd;
    logic        sca, tpa;
  } vec_t;

  vec_t tbl[17];

  initial begin : main
    int steps, nstb, bc0_seen, busy_low, drops;
    logic found, sent;
    logic [5:0]  s_cmd[4];
    logic [11:0] s_bx[4];
    int          s_idx[4];

    //            rst   sc    scmd    tp    tcmd    tpbx     bxn     n  stb   cmd     sca   tpa
    tbl[0]  = '{1'b1, 1'b0, 6'd0,  1'b0, 6'd0,  12'd0,   12'd0,   2, 1'b0, 6'd0,  1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 6'd6,  1'b0, 6'd0,  12'd0,   12'd0,   1, 1'b0, 6'd0,  1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 6'd6,  1'b0, 6'd0,  12'd0,   12'd0,   1, 1'b1, 6'd6,  1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 6'd6,  1'b0, 6'd0,  12'd0,   12'd0,   1, 1'b0, 6'd6,  1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 6'd5,  1'b0, 6'd0,  12'd0,   12'd0,   6, 1'b0, 6'd6,  1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 6'd5,  1'b0, 6'd0,  12'd0,   12'd0,   1, 1'b1, 6'd5,  1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  12'd0,   12'd0,   7, 1'b0, 6'd5,  1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 6'd0,  1'b1, 6'd9,  12'd100, 12'd99,  1, 1'b0, 6'd5,  1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 6'd2,  1'b1, 6'd9,  12'd100, 12'd100, 1, 1'b1, 6'd9,  1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 6'd2,  1'b0, 6'd9,  12'd100, 12'd101, 7, 1'b0, 6'd9,  1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 6'd2,  1'b0, 6'd9,  12'd100, 12'd102, 1, 1'b1, 6'd2,  1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  12'd0,   12'd0,   5, 1'b0, 6'd2,  1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 6'd0,  1'b1, 6'd12, 12'd200, 12'd200, 1, 1'b0, 6'd2,  1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 6'd0,  1'b1, 6'd12, 12'd200, 12'd201, 2, 1'b0, 6'd2,  1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 6'd0,  1'b1, 6'd12, 12'd200, 12'd200, 1, 1'b1, 6'd12, 1'b0, 1'b1};
    tbl[15] = '{1'b1, 1'b1, 6'd63, 1'b0, 6'd0,  12'd0,   12'd0,   1, 1'b0, 6'd0,  1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 6'd63, 1'b0, 6'd0,  12'd0,   12'd0,   1, 1'b1, 6'd63, 1'b1, 1'b0};

    for (int i = 0; i < 17; i++) begin
      rst = tbl[i].rst; sc_req = tbl[i].sc_req; sc_cmd = tbl[i].sc_cmd;
      tp_req = tbl[i].tp_req; tp_cmd = tbl[i].tp_cmd; tp_bx = tbl[i].tp_bx; bxn = tbl[i].bxn;
      for (int k = 0; k < tbl[i].n; k++) tick();
      check($sformatf("vec%0d", i), {23'd0, stb, cmd, sca, tpa},
            {23'd0, tbl[i].stb, tbl[i].cmd, tbl[i].sca, tbl[i].tpa});
    end
    sc_req = 1'b0; tp_req = 1'b0;

    // tp match inside holdoff must wait a full short orbit
    rst = 1'b1; mstep("tpblk_rst"); rst = 1'b0;
    sel = 1'b0; bxn = 12'd90;
    for (int k = 0; k < 20 && bxn != 12'd94; k++) mstep("tpblk_run");
    sc_req = 1'b1; sc_cmd = 6'd6;
    mstep("tpblk_sc");
    check("tpblk_sc_at_95", {19'd0, sca, bxn}, {19'd0, 1'b1, 12'd95});
    sc_req = 1'b0; tp_req = 1'b1; tp_cmd = 6'd9; tp_bx = 12'd100;
    found = 1'b0; steps = 0;
    for (int k = 0; k < 2000 && !found; k++) begin
      mstep("tpblk_wait");
      steps++;
      if (tpa) found = 1'b1;
    end
    tp_req = 1'b0;
    check("tpblk_found", {31'd0, found}, 32'd1);
    check("tpblk_delay", steps, 930);
    check("tpblk_bx", {20'd0, bxn}, 32'd101);

`ifdef TTC_RESYNC_SEQ_EN
    // Full sequence on the long orbit with a second resync arriving in L1R
    rst = 1'b1; mstep("seq_rst"); rst = 1'b0;
    sel = 1'b1; bxn = 12'd3400;
    resync = 1'b1; mstep("seq_req"); resync = 1'b0;
    nstb = 0; sent = 1'b0; busy_low = 0; drops = 0;
    for (int k = 0; k < 5000 && nstb < 4; k++) begin
      if (nstb == 1 && !sent) begin resync = 1'b1; sent = 1'b1; end
      mstep("seq_run");
      resync = 1'b0;
      if (drop) drops++;
      if (stb) begin
        s_cmd[nstb] = cmd; s_bx[nstb] = bxn; s_idx[nstb] = k; nstb++;
      end else if (!busy) busy_low++;
    end
    check("seq_count", nstb, 4);
    check("seq_first_latency", s_idx[0], 0);
    check("seq_cmds", {8'd0, s_cmd[0], s_cmd[1], s_cmd[2], s_cmd[3]},
          {8'd0, 6'd7, 6'd3, 6'd1, 6'd6});
    check("seq_l1r_gap", s_idx[1] - s_idx[0], GAP);
    check("seq_bc0_bx", {20'd0, s_bx[2]}, 32'd0);
    check("seq_start_gap", s_idx[3] - s_idx[2], GAP);
    check("seq_busy_low", busy_low, 0);
    check("seq_drops", drops, 1);
    mstep("seq_idle");
    check("seq_idle_busy", {31'd0, busy}, 32'd0);

    // Reset while waiting in ORB aborts the sequence
    sel = 1'b0; bxn = 12'd100;
    resync = 1'b1; mstep("rstorb_req"); resync = 1'b0;
    nstb = 0;
    for (int k = 0; k < 100 && nstb < 2; k++) begin
      mstep("rstorb_run");
      if (stb) nstb++;
    end
    check("rstorb_two_strobes", nstb, 2);
    for (int k = 0; k < 5; k++) mstep("rstorb_wait");
    rst = 1'b1; mstep("rstorb_rst"); rst = 1'b0;
    check("rstorb_outputs", {21'd0, busy, drop, tpa, sca, stb, cmd}, 32'd0);
    bc0_seen = 0;
    for (int k = 0; k < 2000; k++) begin
      mstep("rstorb_after");
      if (stb) bc0_seen++;
    end
    check("rstorb_no_strobe", bc0_seen, 0);
`else
    // Without the sequencer resync requests have no effect
    rst = 1'b1; mstep("noseq_rst"); rst = 1'b0;
    resync = 1'b1; mstep("noseq_req"); resync = 1'b0;
    nstb = 0; busy_low = 0;
    for (int k = 0; k < 50; k++) begin
      mstep("noseq_run");
      if (stb) nstb++;
      if (busy || drop) busy_low++;
    end
    check("noseq_no_strobe", nstb, 0);
    check("noseq_no_busy", busy_low, 0);
`endif

    // Random traffic against the model
    sel = 1'b0; bxn = 12'd0;
    rst = 1'b1; mstep("rand_rst"); rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!sc_req && $urandom_range(0, 7) == 0) begin
        sc_req = 1'b1; sc_cmd = 6'($urandom);
      end else if (sc_req && $urandom_range(0, 39) == 0) sc_req = 1'b0;
      if (!tp_req && $urandom_range(0, 9) == 0) begin
        tp_req = 1'b1; tp_cmd = 6'($urandom); tp_bx = 12'(bxn + 12'($urandom_range(0, 30)));
      end else if (tp_req && $urandom_range(0, 39) == 0) tp_req = 1'b0;
      resync = ($urandom_range(0, 299) == 0);
      rst    = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 999) == 0) sel = ~sel;
      mstep("random");
      resync = 1'b0; rst = 1'b0;
      if (sca) sc_req = 1'b0;
      if (tpa) tp_req = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
